// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer on the reference clock with retry, stats and FAIL.
// Optional PLL_RST_SEQ_GLITCH_FILTER_EN: in RUN a lock loss needs two consecutive low locked_s cycles.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1000,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             restart,
  input  logic             clear_stats,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fail,
  output logic             lost_lock,
  output logic [3:0]       retry_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int TW      = $clog2(MAX_CNT);

  localparam logic [TW-1:0] PR_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] LT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SC_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     cnt, cnt_n;
  logic [3:0]        retry_n;
  logic [CNT_W-1:0]  llc_n;
  logic              lost_n;
  logic              locked_m, locked_s;
  logic              lock_lost;

  // pll_locked is asynchronous to clk; nothing downstream may look at it directly
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
  logic locked_d;

  always_ff @(posedge clk) begin
    if (rst) locked_d <= 1'b0;
    else     locked_d <= locked_s;
  end

  assign lock_lost = !locked_s && !locked_d;
`else
  assign lock_lost = !locked_s;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_cnt;
    llc_n   = lock_loss_cnt;
    lost_n  = lost_lock;
    if (clear_stats) begin
      llc_n  = '0;
      lost_n = 1'b0;
    end
    if (restart) begin
      state_n = S_PLL_RST;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == PR_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else if (cnt == LT_LAST) begin
            cnt_n = '0;
            if (retry_cnt == RETRY_MAX) state_n = S_FAIL;
            else begin
              state_n = S_PLL_RST;
              retry_n = retry_cnt + 1'b1;
            end
          end else cnt_n = cnt + 1'b1;
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == SC_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        end
        S_RUN: begin
          // a loss in the same cycle as clear_stats overrides the clear
          if (lock_lost) begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
            retry_n = '0;
            lost_n  = 1'b1;
            if (clear_stats)             llc_n = CNT_W'(1);
            else if (lock_loss_cnt != '1) llc_n = lock_loss_cnt + 1'b1;
          end
        end
        S_FAIL: ;
        default: begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // outputs are registered from the next state so they stay glitch-free yet align with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_PLL_RST;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      lost_lock     <= 1'b0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= llc_n;
      lost_lock     <= lost_n;
      pll_rst       <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
      sys_rst       <= (state_n != S_RUN);
      ready         <= (state_n == S_RUN);
      fail          <= (state_n == S_FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - randomized scoreboard bench for pll_reset_sequencer.
module tb_pll_reset_sequencer;

  localparam int PR  = 4;
  localparam int LT  = 32;
  localparam int SC  = 16;
  localparam int MR  = 3;
  localparam int CW  = 8;
  localparam int ATT = PR + LT;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
  localparam int LOSS_LAT = 4;
`else
  localparam int LOSS_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          restart = 1'b0;
  logic          clear_stats = 1'b0;
  logic          pll_rst, sys_rst, ready, fail, lost_lock;
  logic [3:0]    retry_cnt;
  logic [CW-1:0] lock_loss_cnt;
  logic [2:0]    state_o;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .clear_stats(clear_stats), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .ready(ready), .fail(fail), .lost_lock(lost_lock), .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int st;
    int retry;
    int llc;
    int lost;
  } exp_t;

  exp_t exp_q[$];
  int   m_llc = 0;
  int   m_lost = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   prev_st = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic void expect_at(input int at, input int st, input int retry);
    exp_t e;
    e.at = at; e.st = st; e.retry = retry; e.llc = m_llc; e.lost = m_lost;
    exp_q.push_back(e);
  endfunction

  task automatic goto(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_pll_rst"}, int'(pll_rst), 1);
    chk({tag, "_sys_rst"}, int'(sys_rst), 1);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_retry"}, int'(retry_cnt), 0);
    chk({tag, "_llc"}, int'(lock_loss_cnt), 0);
    chk({tag, "_lost"}, int'(lost_lock), 0);
  endtask

  // Each state change the DUT shows is matched against the next predicted event
  always @(negedge clk) begin
    if (mon_en && int'(state_o) != prev_st) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_transition at edge %0d: got state %0d, expected state %0d",
                 cyc, state_o, prev_st);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("edge", cyc, e.at);
        chk("state_o", int'(state_o), e.st);
        chk("pll_rst", int'(pll_rst), int'(e.st == 0 || e.st == 4));
        chk("sys_rst", int'(sys_rst), int'(e.st != 3));
        chk("ready", int'(ready), int'(e.st == 3));
        chk("fail", int'(fail), int'(e.st == 4));
        chk("retry_cnt", int'(retry_cnt), e.retry);
        chk("lock_loss_cnt", int'(lock_loss_cnt), e.llc);
        chk("lost_lock", int'(lost_lock), e.lost);
      end
      prev_st = int'(state_o);
    end
  end

  // Sequence out of reset with pll_locked already high
  task automatic latency_seq(input int c);
    expect_at(c + PR, 1, 0);
    expect_at(c + PR + 1, 2, 0);
    expect_at(c + PR + 1 + SC, 3, 0);
    goto(c + PR - 1);
    chk("pll_rst_last_edge", int'(pll_rst), 1);
    goto(c + PR + SC);
    chk("sys_rst_before_release", int'(sys_rst), 1);
    chk("ready_before_release", int'(ready), 0);
    goto(c + PR + 1 + SC);
  endtask

  // One sequence starting in PLL_RST (cnt=0 after edge s) with pll_locked low
  task automatic run_iter(input int s, input bit sat, output int s_next);
    int k, a, e, f, g, h, r;
    bit clr;
    k = sat ? 0 : int'($urandom_range(0, MR + 1));
    for (int i = 0; i < k; i++) begin
      expect_at(s + i * ATT + PR, 1, i);
      expect_at(s + (i + 1) * ATT, (i == MR) ? 4 : 0, (i == MR) ? i : i + 1);
    end
    if (k == MR + 1) begin
      r = s + k * ATT + int'($urandom_range(1, 10));
      goto(r);
      restart = 1'b1;
      expect_at(r + 1, 0, 0);
      goto(r + 1);
      restart = 1'b0;
      s_next = r + 1;
      return;
    end
    a = s + k * ATT;
    expect_at(a + PR, 1, k);
    e = a + PR + int'($urandom_range(0, 25));
    goto(e);
    pll_locked = 1'b1;
    expect_at(e + 3, 2, k);
    if (!sat && $urandom_range(0, 2) == 0) begin
      f = e + 3 + int'($urandom_range(1, 10));
      goto(f);
      pll_locked = 1'b0;
      expect_at(f + 3, 1, k);
      g = f + 3 + int'($urandom_range(0, 10));
      goto(g);
      pll_locked = 1'b1;
      expect_at(g + 3, 2, k);
      e = g;
    end
    expect_at(e + 3 + SC, 3, k);
    goto(e + 3 + SC);
    if (!sat && $urandom_range(0, 3) == 0) begin
      clear_stats = 1'b1;
      m_llc = 0;
      m_lost = 0;
      goto(e + 4 + SC);
      clear_stats = 1'b0;
      chk("clear_alone_llc", int'(lock_loss_cnt), 0);
      chk("clear_alone_lost", int'(lost_lock), 0);
    end
    h = e + 5 + SC + int'($urandom_range(0, 6));
    if (!sat && $urandom_range(0, 4) == 0) begin
      goto(h);
      restart = 1'b1;
      pll_locked = 1'b0;
      expect_at(h + 1, 0, 0);
      goto(h + 1);
      restart = 1'b0;
      s_next = h + 1;
      return;
    end
    goto(h);
    pll_locked = 1'b0;
    clr = !sat && ($urandom_range(0, 2) == 0);
    if (clr) m_llc = 1;
    else if (m_llc < (1 << CW) - 1) m_llc++;
    m_lost = 1;
    expect_at(h + LOSS_LAT, 0, 0);
    if (clr) begin
      goto(h + LOSS_LAT - 1);
      clear_stats = 1'b1;
      goto(h + LOSS_LAT);
      clear_stats = 1'b0;
    end
    s_next = h + LOSS_LAT;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, g, x, s, a, e;
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    prev_st = 0;
    mon_en = 1'b1;
    c0 = cyc;
    rst = 1'b0;
    latency_seq(c0);

    g = cyc + 4;
    goto(g);
    pll_locked = 1'b0;
    goto(g + 1);
    pll_locked = 1'b1;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
    goto(g + 5);
    chk("glitch_state", int'(state_o), 3);
    chk("glitch_llc", int'(lock_loss_cnt), 0);
    x = g + 5;
`else
    m_llc = 1;
    m_lost = 1;
    expect_at(g + 3, 0, 0);
    s = g + 3;
    expect_at(s + PR, 1, 0);
    expect_at(s + PR + 1, 2, 0);
    expect_at(s + PR + 1 + SC, 3, 0);
    x = s + PR + 1 + SC + 2;
`endif
    goto(x);
    restart = 1'b1;
    pll_locked = 1'b0;
    expect_at(x + 1, 0, 0);
    goto(x + 1);
    restart = 1'b0;
    s = x + 1;

    for (int i = 0; i < 40; i++) run_iter(s, 1'b0, s);
    for (int i = 0; i < 260; i++) run_iter(s, 1'b1, s);
    chk("llc_saturated", int'(lock_loss_cnt), (1 << CW) - 1);

    a = s;
    expect_at(a + PR, 1, 0);
    e = a + PR + 2;
    goto(e);
    pll_locked = 1'b1;
    expect_at(e + 3, 2, 0);
    goto(e + 11);
    rst = 1'b1;
    m_llc = 0;
    m_lost = 0;
    expect_at(e + 12, 0, 0);
    goto(e + 12);
    check_reset("rst_in_stable");
    rst = 1'b0;
    latency_seq(cyc);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("events_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Reset/lock sequencer that sits directly around the system PLL wrapper.
- Drives the PLL's `rst` input and consumes its asynchronous `locked` output.
- Generates the system reset and ready signal for logic clocked by the PLL outputs.
- Runs on the free-running 50 MHz reference clock, never on a PLL output. Retries PLL reset on lock timeout, counts lock losses, and declares failure after bounded retries.

Parameters:
- PLL_RST_CYCLES, 4, cycles pll_rst is held high per attempt (≥1)
- LOCK_TIMEOUT, 50000, cycles to wait for lock before retrying (≥2)
- STABLE_CYCLES, 1000, consecutive synchronized-locked cycles required before releasing sys_rst (≥1)
- MAX_RETRIES, 3, retries after the initial attempt before FAIL (≤15)
- CNT_W, 8, width of lock_loss_cnt

Ports:
- clk  in  1  50 MHz free-running reference clock
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL locked output, asynchronous to clk
- restart  in  1  single-cycle request to restart the whole sequence
- clear_stats  in  1  clears lock_loss_cnt and lost_lock
- pll_rst  out  1  reset to the PLL
- sys_rst  out  1  system reset, active-high
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- lost_lock  out  1  sticky: lock was lost while in RUN
- retry_cnt  out  4  retries used in the current sequence
- lock_loss_cnt  out  CNT_W  saturating count of lock losses in RUN
- state_o  out  3  debug state encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high, `rst`. Everything samples on the rising edge of clk.
- Synchronizer: pll_locked passes through a 2-FF synchronizer to give locked_s. Both flops reset to 0. Only locked_s is used internally.
- Reset values: state=PLL_RST, cnt=0, pll_rst=1, sys_rst=1, ready=0, fail=0, lost_lock=0, retry_cnt=0, lock_loss_cnt=0.
- Outputs are Moore, registered from state:
  - pll_rst=1 in PLL_RST and FAIL.
  - sys_rst=0 only in RUN.
  - ready=(state==RUN); fail=(state==FAIL).
- Transitions (priority: rst > restart > per-state rule):
  - PLL_RST: if cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK with cnt=0; else cnt++.
  - WAIT_LOCK:
    - if locked_s, go to STABLE with cnt=0;
    - else if cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES go to FAIL, else retry_cnt++ and go to PLL_RST with cnt=0;
    - else cnt++.
  - STABLE: if !locked_s, go to WAIT_LOCK with cnt=0 (no retry charged); else if cnt==STABLE_CYCLES-1 go to RUN; else cnt++.
  - RUN: if lock is lost, go to PLL_RST with cnt=0, retry_cnt=0, lock_loss_cnt+1 (saturating at all-ones), lost_lock=1.
  - FAIL: held until restart or rst.
- restart, in any state: go to PLL_RST with cnt=0, retry_cnt=0. Statistics (lock_loss_cnt, lost_lock) are unchanged.
- clear_stats: zeroes lock_loss_cnt and lost_lock. If a lock-loss increment occurs in the same cycle, the increment wins: lock_loss_cnt=1, lost_lock=1.
- Latency, with pll_locked high from reset: sys_rst falls exactly PLL_RST_CYCLES+1+STABLE_CYCLES edges after rst deasserts.
- Lock loss in RUN: sys_rst rises on the edge after locked_s falls. It is never deasserted again before a full PLL_RST→STABLE sequence completes.
- Never-locking PLL: FAIL is reached after (MAX_RETRIES+1)×(PLL_RST_CYCLES+LOCK_TIMEOUT) edges.
- Reset mid-operation: rst in any state restores all reset values on the next edge, including the statistics.

Optional Feature:
- PLL_RST_SEQ_GLITCH_FILTER_EN
- Defined: RUN treats lock as lost only after locked_s has been low for 2 consecutive cycles. A 1-cycle low glitch is ignored; sys_rst rises 2 edges after locked_s falls.
- Undefined: a single low cycle of locked_s in RUN is a lock loss (behaviour as specified in Behaviour).

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=16, MAX_RETRIES=3):
- pll_locked=1 throughout, release rst → pll_rst high for 4 edges; sys_rst=1 and ready=0 until edge 21; at edge 21 sys_rst=0, ready=1, retry_cnt=0.
- pll_locked=0 forever → retry_cnt steps 1,2,3 at edges 36,72,108; FAIL at edge 144 with fail=1, pll_rst=1, sys_rst=1. restart pulse → state_o=0, retry_cnt=0, fail=0.
- Lock in RUN, then pll_locked low for 1 cycle → without macro: sys_rst=1, lock_loss_cnt=1, lost_lock=1, state_o=0. With macro: no state change, lock_loss_cnt=0.
- pll_locked drops at cycle 8 of STABLE → return to WAIT_LOCK, retry_cnt unchanged. Relock → full 16-cycle STABLE before ready=1.
- clear_stats asserted in the same cycle as a RUN lock loss, with lock_loss_cnt=5 → lock_loss_cnt=1, lost_lock=1. clear_stats alone later → both 0.
- rst asserted during STABLE, with lock_loss_cnt=3 → next edge: all outputs at reset values, lock_loss_cnt=0, state_o=0.
